// File: rtl/embedding_token_streamer_pkg.sv
// Shared types and constants for the embedding token streamer.
// Optional feature macro: EMBED_STREAM_CLS_EN (prepend a class token to every frame).
package embed_pkg;

   localparam int NUM_TOKENS = 15;
   localparam int EMBED_DIM  = 16;
   localparam int DATA_W     = 8;
   localparam int IDX_W      = 5;
   localparam int ROW_W      = 4;

   typedef logic signed [DATA_W-1:0] elem_t;
   typedef elem_t token_t [0:EMBED_DIM-1];

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   localparam token_t CLS_TOKEN = '{
      8'sh7f, 8'sh80, 8'sh01, 8'shff, 8'sh10, 8'she0, 8'sh33, 8'shc4,
      8'sh00, 8'sh55, 8'shaa, 8'sh0f, 8'shf0, 8'sh21, 8'shde, 8'sh42
   };

endpackage

// File: rtl/embedding_token_streamer_if.sv
// Producer/consumer bundle for the embedding token streamer.
interface embedding_token_streamer_if;
   import embed_pkg::*;

   logic              in_done;
   elem_t             in_result [0:NUM_TOKENS-1][0:EMBED_DIM-1];
   logic              out_valid;
   logic              out_ready;
   token_t            out_token;
   logic [IDX_W-1:0]  out_index;
   logic              out_last;
   logic              busy;
   logic              frame_done;
   logic              overrun;

   modport slave (
      input  in_done, in_result, out_ready,
      output out_valid, out_token, out_index, out_last, busy, frame_done, overrun
   );

   modport master (
      output in_done, in_result, out_ready,
      input  out_valid, out_token, out_index, out_last, busy, frame_done, overrun
   );

endinterface

// File: rtl/embedding_token_streamer_buffer.sv
// Full-matrix capture register with a single indexed row read port.
module token_buffer
   import embed_pkg::*;
(
   input  logic              clk,
   input  logic              i_wr_en,
   input  elem_t             i_wr_data [0:NUM_TOKENS-1][0:EMBED_DIM-1],
   input  logic [ROW_W-1:0]  i_rd_row,
   output token_t            o_rd_token
);

   // Contents are don't-care after reset, so the array carries no reset.
   elem_t r_mem [0:NUM_TOKENS-1][0:EMBED_DIM-1];

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem <= i_wr_data;
      end
   end

   always_comb begin
      for (int j = 0; j < EMBED_DIM; j++) begin
         o_rd_token[j] = r_mem[i_rd_row][j];
      end
   end

endmodule

// File: rtl/embedding_token_streamer.sv
// Captures the embedding matrix on a done rising edge and streams it one token per beat.
// Optional feature macro: EMBED_STREAM_CLS_EN (class token emitted as beat 0).
//
// state     | meaning
// ST_IDLE   | waiting for in_done rising edge
// ST_STREAM | presenting tokens, advancing on handshake
// ST_FINISH | one-cycle frame_done pulse
module embedding_token_streamer
   import embed_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   embedding_token_streamer_if.slave   bus
);

   state_t            r_state, w_state_nxt;
   logic [IDX_W-1:0]  r_cnt, w_cnt_nxt;
   logic              r_done_q;
   logic              r_overrun, w_overrun_nxt;
   logic              w_rise, w_capture, w_valid, w_hs, w_last;
   logic [ROW_W-1:0]  w_rd_row;
   token_t            w_row_token;
   token_t            w_token_sel;

   token_buffer u_buffer (
      .clk        (clk),
      .i_wr_en    (w_capture),
      .i_wr_data  (bus.in_result),
      .i_rd_row   (w_rd_row),
      .o_rd_token (w_row_token)
   );

   assign w_rise  = bus.in_done & ~r_done_q;
   assign w_valid = (r_state == ST_STREAM);
   assign w_hs    = w_valid & bus.out_ready;

`ifdef EMBED_STREAM_CLS_EN
   // Beat 0 is the class token; matrix row r rides on beat r+1.
   assign w_last   = (r_cnt == IDX_W'(NUM_TOKENS));
   assign w_rd_row = ((r_cnt == '0) || (r_cnt > IDX_W'(NUM_TOKENS))) ? '0 : ROW_W'(r_cnt - 1'b1);
   always_comb begin
      for (int j = 0; j < EMBED_DIM; j++) begin
         w_token_sel[j] = (r_cnt == '0) ? CLS_TOKEN[j] : w_row_token[j];
      end
   end
`else
   assign w_last   = (r_cnt == IDX_W'(NUM_TOKENS - 1));
   assign w_rd_row = (r_cnt >= IDX_W'(NUM_TOKENS)) ? '0 : ROW_W'(r_cnt);
   always_comb begin
      for (int j = 0; j < EMBED_DIM; j++) begin
         w_token_sel[j] = w_row_token[j];
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_done_q  <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_done_q  <= bus.in_done;
         r_overrun <= w_overrun_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_capture     = 1'b0;
      w_overrun_nxt = r_overrun;
      case (r_state)
         ST_IDLE: begin
            if (w_rise) begin
               w_capture   = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (w_rise) w_overrun_nxt = 1'b1;
            if (w_hs) begin
               w_cnt_nxt = r_cnt + 1'b1;
               if (w_last) w_state_nxt = ST_FINISH;
            end
         end
         ST_FINISH: begin
            if (w_rise) w_overrun_nxt = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Token/index/last are forced to zero outside STREAM so idle outputs match reset values.
   always_comb begin
      bus.out_valid  = w_valid;
      bus.out_index  = w_valid ? r_cnt : '0;
      bus.out_last   = w_valid & w_last;
      bus.busy       = (r_state != ST_IDLE);
      bus.frame_done = (r_state == ST_FINISH);
      bus.overrun    = r_overrun;
      for (int j = 0; j < EMBED_DIM; j++) begin
         bus.out_token[j] = w_valid ? w_token_sel[j] : '0;
      end
   end

endmodule

// File: tb/tb_embedding_token_streamer.sv
// Self-checking bench for embedding_token_streamer: table-driven frames plus corner sequences.
module tb_embedding_token_streamer;
   import embed_pkg::*;

`ifdef EMBED_STREAM_CLS_EN
   localparam int NUM_BEATS = NUM_TOKENS + 1;
`else
   localparam int NUM_BEATS = NUM_TOKENS;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   embedding_token_streamer_if bus ();

   embedding_token_streamer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [IDX_W-1:0] idx;
      token_t           tok;
      logic             last;
   } beat_t;

   typedef struct {
      string      name;
      int         sel;
      logic [3:0] pat;
   } vec_t;

   beat_t            sb [$];
   int               checks = 0;
   int               errors = 0;
   int               hs_count = 0;
   logic             expect_fd = 1'b0;
   logic             prev_stall = 1'b0;
   token_t           prev_tok;
   logic [IDX_W-1:0] prev_idx;
   logic             prev_last;

   function automatic logic [127:0] pack_tok(token_t t);
      logic [127:0] r;
      r = '0;
      for (int j = 0; j < EMBED_DIM; j++) r[127-8*j -: 8] = t[j];
      return r;
   endfunction

   function automatic elem_t gen(int sel, int i, int j);
      int v;
      case (sel)
         0:       v = i*16 + j - 120;
         1:       v = (i*16 + j)*7 + 3;
         2:       v = 100 - (i*16 + j);
         default: v = (i*37) ^ (j*11);
      endcase
      return elem_t'(v);
   endfunction

   function automatic int exp_cycles(logic [3:0] pat);
      int h;
      int c;
      logic [1:0] ph;
      h = 0;
      c = 0;
      ph = 2'd0;
      while (h < NUM_BEATS) begin
         if (pat[ph]) h++;
         ph = ph + 2'd1;
         c++;
      end
      return c + 1;
   endfunction

   task automatic chki(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic chkt(string name, token_t act, token_t exp);
      checks++;
      if (pack_tok(act) !== pack_tok(exp)) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, pack_tok(act), pack_tok(exp));
      end
   endtask

   task automatic fill(int sel);
      for (int i = 0; i < NUM_TOKENS; i++)
         for (int j = 0; j < EMBED_DIM; j++)
            bus.in_result[i][j] = gen(sel, i, j);
   endtask

   task automatic push_frame(int sel);
      beat_t b;
      int    row;
      for (int k = 0; k < NUM_BEATS; k++) begin
         b.idx  = IDX_W'(k);
         b.last = (k == NUM_BEATS - 1);
`ifdef EMBED_STREAM_CLS_EN
         row = k - 1;
`else
         row = k;
`endif
         for (int j = 0; j < EMBED_DIM; j++) begin
`ifdef EMBED_STREAM_CLS_EN
            b.tok[j] = (k == 0) ? CLS_TOKEN[j] : gen(sel, row, j);
`else
            b.tok[j] = gen(sel, row, j);
`endif
         end
         sb.push_back(b);
      end
   endtask

   task automatic start_capture(int sel, bit push);
      @(posedge clk); #1;
      fill(sel);
      if (push) push_frame(sel);
      bus.out_ready = 1'b0;
      bus.in_done   = 1'b1;
      @(posedge clk); #1;
      bus.in_done   = 1'b0;
      chki("latency_valid", int'(bus.out_valid), 1);
      chki("latency_index", int'(bus.out_index), 0);
   endtask

   task automatic stream(logic [3:0] pat, int budget, output int cycles);
      logic [1:0] ph;
      ph = 2'd0;
      cycles = 0;
      while (bus.busy && cycles < budget) begin
         bus.out_ready = pat[ph];
         ph = ph + 2'd1;
         @(posedge clk); #1;
         cycles++;
      end
      bus.out_ready = 1'b0;
      if (bus.busy) begin
         checks++;
         errors++;
         $display("FAIL stream_timeout actual=busy required=idle within %0d cycles", budget);
      end
   endtask

   // Scoreboard monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         expect_fd  = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (expect_fd || bus.frame_done)
            chki("frame_done", int'(bus.frame_done), int'(expect_fd));
         expect_fd = 1'b0;
         if (prev_stall) begin
            chki("stall_valid_held", int'(bus.out_valid), 1);
            chkt("stall_token", bus.out_token, prev_tok);
            chki("stall_index", int'(bus.out_index), int'(prev_idx));
            chki("stall_last", int'(bus.out_last), int'(prev_last));
         end
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat actual=index %0d required=no beat", bus.out_index);
            end else begin
               beat_t e;
               e = sb.pop_front();
               chki("beat_index", int'(bus.out_index), int'(e.idx));
               chkt("beat_token", bus.out_token, e.tok);
               chki("beat_last", int'(bus.out_last), int'(e.last));
               if (e.last) expect_fd = 1'b1;
            end
            hs_count++;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_tok   = bus.out_token;
         prev_idx   = bus.out_index;
         prev_last  = bus.out_last;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=still running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs [4];
      int   cyc;
      int   base;
      int   n;
      int   fd;
      token_t zero_tok;

      vecs[0] = '{"ready_all",    0, 4'b1111};
      vecs[1] = '{"ready_1001",   0, 4'b1001};
      vecs[2] = '{"ready_0110",   1, 4'b0110};
      vecs[3] = '{"ready_sparse", 2, 4'b0001};

      for (int j = 0; j < EMBED_DIM; j++) zero_tok[j] = '0;
      bus.in_done   = 1'b0;
      bus.out_ready = 1'b0;
      fill(3);

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chki("rst_valid",      int'(bus.out_valid), 0);
      chki("rst_index",      int'(bus.out_index), 0);
      chki("rst_last",       int'(bus.out_last), 0);
      chki("rst_busy",       int'(bus.busy), 0);
      chki("rst_frame_done", int'(bus.frame_done), 0);
      chki("rst_overrun",    int'(bus.overrun), 0);
      chkt("rst_token",      bus.out_token, zero_tok);
      rst_n = 1'b1;

      for (int v = 0; v < 4; v++) begin
         base = hs_count;
         start_capture(vecs[v].sel, 1'b1);
         stream(vecs[v].pat, 200, cyc);
         chki({vecs[v].name, "_beats"},   hs_count - base, NUM_BEATS);
         chki({vecs[v].name, "_cycles"},  cyc, exp_cycles(vecs[v].pat));
         chki({vecs[v].name, "_sb_left"}, sb.size(), 0);
         chki({vecs[v].name, "_overrun"}, int'(bus.overrun), 0);
      end

      // Second in_done rise mid-frame must not disturb the captured frame
      base = hs_count;
      start_capture(0, 1'b1);
      bus.out_ready = 1'b1;
      n = 0;
      while (hs_count - base < 5 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chki("ovr_reached_beat5", int'(hs_count - base >= 5), 1);
      fill(2);
      bus.in_done = 1'b1;
      @(posedge clk); #1;
      bus.in_done = 1'b0;
      chki("ovr_set", int'(bus.overrun), 1);
      stream(4'b1111, 100, cyc);
      chki("ovr_beats",  hs_count - base, NUM_BEATS);
      chki("ovr_sticky", int'(bus.overrun), 1);
      chki("ovr_sb_left", sb.size(), 0);

      // Reset mid-frame, then a fresh frame
      base = hs_count;
      start_capture(1, 1'b1);
      bus.out_ready = 1'b1;
      n = 0;
      while (hs_count - base < 7 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chki("rst_mid_reached_beat7", int'(hs_count - base >= 7), 1);
      rst_n = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      chki("rst_mid_valid",   int'(bus.out_valid), 0);
      chki("rst_mid_busy",    int'(bus.busy), 0);
      chki("rst_mid_overrun", int'(bus.overrun), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      base = hs_count;
      start_capture(3, 1'b1);
      stream(4'b1111, 100, cyc);
      chki("rst_new_beats",   hs_count - base, NUM_BEATS);
      chki("rst_new_overrun", int'(bus.overrun), 0);
      chki("rst_new_sb_left", sb.size(), 0);

      // in_done held high across two frame lengths: one capture only
      @(posedge clk); #1;
      base = hs_count;
      fill(1);
      push_frame(1);
      bus.in_done   = 1'b1;
      bus.out_ready = 1'b1;
      fd = 0;
      for (int c = 0; c < 3*(NUM_BEATS + 2); c++) begin
         @(posedge clk); #1;
         if (bus.frame_done) fd++;
      end
      bus.in_done   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chki("held_frames",  fd, 1);
      chki("held_beats",   hs_count - base, NUM_BEATS);
      chki("held_busy",    int'(bus.busy), 0);
      chki("held_overrun", int'(bus.overrun), 0);
      chki("held_sb_left", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/embedding_token_streamer.md
# embedding_token_streamer

Parallel-to-stream reader for the linear embedding output. Captures the full 15×16 signed int8 embedding matrix when the producer raises `done`, then emits it one token (row of 16 elements) per beat over a valid/ready interface toward the transformer encoder input. Decouples the embedding stage's one-shot parallel result from the encoder's backpressured token consumption.

## Interface
- `NUM_TOKENS`, 15, rows in the embedding matrix
- `EMBED_DIM`, 16, elements per token
- `DATA_W`, 8, signed element width
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_done`  in  1  producer result-valid strobe; level or pulse, sampled on rising edge
- `in_result`  in  NUM_TOKENS×EMBED_DIM×DATA_W  unpacked signed matrix `[0:NUM_TOKENS-1][0:EMBED_DIM-1]`
- `out_valid`  out  1  token beat valid
- `out_ready`  in  1  consumer accepts beat
- `out_token`  out  EMBED_DIM×DATA_W  unpacked signed row `[0:EMBED_DIM-1]`
- `out_index`  out  5  token index of current beat
- `out_last`  out  1  high on the final beat of a frame
- `busy`  out  1  frame captured and not yet fully streamed
- `frame_done`  out  1  one-cycle pulse after last beat accepted
- `overrun`  out  1  sticky: `in_done` rising edge seen while busy

## Operation
- FSM states: IDLE, STREAM, FINISH.
- IDLE: on `in_done` rising edge (edge-detected against registered previous value), copy entire `in_result` into internal buffer, clear row counter, go to STREAM.
- STREAM: `out_valid`=1; `out_token` = buffer row selected by counter; `out_index` = counter (plus offset, see Configuration). Handshake = `out_valid && out_ready`. On handshake, counter increments; on handshake with `out_last`=1, go to FINISH.
- FINISH: `frame_done`=1 for exactly one cycle, return to IDLE.
- `busy` = 1 in STREAM and FINISH.
- `in_done` rising edge while in STREAM or FINISH: ignored (buffer untouched), `overrun` set to 1; cleared only by reset.
- Elements passed through unchanged; no arithmetic, no sign change, no saturation.
- Reset mid-frame: all state discarded, FSM to IDLE, buffer contents don't-care; no partial frame resumes.

## Timing
- Reset values: `out_valid`=0, `out_token`=all 0, `out_index`=0, `out_last`=0, `busy`=0, `frame_done`=0, `overrun`=0; FSM IDLE; edge-detect register 0 (so `in_done` held high through reset release counts as a rising edge on first clock).
- Capture latency: `in_done` rise sampled at edge N → `out_valid`=1 with row 0 from edge N+1.
- With `out_ready` held high: one token per cycle, NUM_TOKENS beats on consecutive cycles, `frame_done` the cycle after the last beat; next capture earliest the cycle after `frame_done`.
- While `out_valid && !out_ready`: `out_token`, `out_index`, `out_last` held stable.
- `out_valid` never drops without a handshake once raised.
- All outputs registered or driven only from registered state; no combinational path from `out_ready` to `out_valid`.

## Configuration
- `EMBED_STREAM_CLS_EN` defined: a class token is emitted as beat 0 before the matrix rows; frame = NUM_TOKENS+1 beats (16). CLS values come from a package constant array `CLS_TOKEN` (EMBED_DIM signed DATA_W). `out_index` runs 0..NUM_TOKENS, with CLS at 0 and matrix row r at r+1.
- Undefined: frame = NUM_TOKENS beats, `out_index` = matrix row 0..NUM_TOKENS-1; `CLS_TOKEN` unused.

## Structure
- Shared package `embed_pkg`: `NUM_TOKENS`, `EMBED_DIM`, `DATA_W`, `typedef logic signed [DATA_W-1:0] elem_t`, `typedef elem_t token_t [0:EMBED_DIM-1]`, FSM state enum, `CLS_TOKEN`.
- One sub-module, `token_buffer`: NUM_TOKENS×token_t register array with full-matrix parallel write and one indexed row read port.

## Test plan
- Reset, pulse `in_done` with `in_result[i][j] = i*16+j-120`, `out_ready`=1 → 15 consecutive beats, beat k row equals k*16+j-120, `out_last` only on beat 14, `frame_done` one cycle later.
- Same frame, `out_ready` toggled 1,0,0,1 repeating → each row emitted exactly once, outputs stable across stalled cycles, order 0..14.
- Second `in_done` rise at beat 5 with different data → `overrun`=1 sticky, streamed rows still from first capture.
- `rst_n` low at beat 7 then released, `in_done` pulsed with new data → stream restarts at index 0 with new data, `overrun`=0.
- `in_done` held high continuously across two frames → exactly one frame captured (single rising edge), no spurious second frame.
- With `EMBED_STREAM_CLS_EN`: 16 beats, beat 0 equals `CLS_TOKEN`, `out_index` 0..15, `out_last` on index 15.
